// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with writeback mux and load alignment; drives the register-file write port.
// Optional retired-instruction counter enabled by defining MEM_WB_PERF_CNT_EN.
module mem_wb_stage #(
    parameter int CNT_WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 mem_valid,
    input  logic                 mem_regwrite,
    input  logic [4:0]           mem_rd,
    input  logic [1:0]           mem_wbsel,
    input  logic [2:0]           mem_funct3,
    input  logic [31:0]          mem_alu_out,
    input  logic [31:0]          mem_rdata,
    input  logic [31:0]          mem_pc,
    input  logic [31:0]          mem_u_imm,
    output logic                 wb_valid,
    output logic                 rf_load,
    output logic [4:0]           rf_dest,
    output logic [31:0]          rf_in,
    output logic [CNT_WIDTH-1:0] instret
);

    logic        r_valid;
    logic        r_regwrite;
    logic [4:0]  r_rd;
    logic [1:0]  r_wbsel;
    logic [2:0]  r_funct3;
    logic [31:0] r_alu_out;
    logic [31:0] r_rdata;
    logic [31:0] r_pc;
    logic [31:0] r_u_imm;

    // Flush wins over stall so a simultaneous request always yields a bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid    <= 1'b0;
            r_regwrite <= 1'b0;
            r_rd       <= '0;
            r_wbsel    <= '0;
            r_funct3   <= '0;
            r_alu_out  <= '0;
            r_rdata    <= '0;
            r_pc       <= '0;
            r_u_imm    <= '0;
        end else if (flush) begin
            r_valid    <= 1'b0;
            r_regwrite <= 1'b0;
            r_rd       <= '0;
            r_wbsel    <= '0;
            r_funct3   <= '0;
            r_alu_out  <= '0;
            r_rdata    <= '0;
            r_pc       <= '0;
            r_u_imm    <= '0;
        end else if (!stall) begin
            r_valid    <= mem_valid;
            r_regwrite <= mem_regwrite;
            r_rd       <= mem_rd;
            r_wbsel    <= mem_wbsel;
            r_funct3   <= mem_funct3;
            r_alu_out  <= mem_alu_out;
            r_rdata    <= mem_rdata;
            r_pc       <= mem_pc;
            r_u_imm    <= mem_u_imm;
        end
    end

    logic [7:0]  w_bytes [4];
    logic [1:0]  w_off;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;
    logic [31:0] w_sel;

    for (genvar gi = 0; gi < 4; gi++) begin : g_bytes
        assign w_bytes[gi] = r_rdata[8*gi +: 8];
    end

    assign w_off  = r_alu_out[1:0];
    assign w_byte = w_bytes[w_off];
    assign w_half = w_off[1] ? r_rdata[31:16] : r_rdata[15:0];

    always_comb begin
        w_load = r_rdata;
        case (r_funct3)
            3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_load = {24'h0, w_byte};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b101:  w_load = {16'h0, w_half};
            default: w_load = r_rdata;
        endcase
    end

    always_comb begin
        w_sel = r_alu_out;
        case (r_wbsel)
            2'b00:   w_sel = r_alu_out;
            2'b01:   w_sel = w_load;
            2'b10:   w_sel = r_pc + 32'd4;
            default: w_sel = r_u_imm;
        endcase
    end

    assign wb_valid = r_valid;
    assign rf_dest  = r_rd;
    assign rf_load  = r_valid & r_regwrite & (r_rd != 5'd0);
    assign rf_in    = r_valid ? w_sel : 32'h0;

`ifdef MEM_WB_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] r_instret;

    // An entry retires on the edge it leaves the stage, so held cycles are not recounted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_instret <= '0;
        end else if (r_valid && !stall && !flush) begin
            r_instret <= r_instret + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign instret = r_instret;
`else
    assign instret = '0;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: driver queues expected writeback state, monitor compares after each edge.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, flush, mem_valid, mem_regwrite;
    logic [4:0]  mem_rd;
    logic [1:0]  mem_wbsel;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_alu_out, mem_rdata, mem_pc, mem_u_imm;
    logic        wb_valid, rf_load;
    logic [4:0]  rf_dest;
    logic [31:0] rf_in;
    logic [63:0] instret;

`ifdef MEM_WB_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    typedef struct {
        logic        v;
        logic        l;
        logic [4:0]  d;
        logic [31:0] din;
        logic [63:0] cnt;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mem_wb_stage #(.CNT_WIDTH(64)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .mem_valid(mem_valid), .mem_regwrite(mem_regwrite), .mem_rd(mem_rd),
        .mem_wbsel(mem_wbsel), .mem_funct3(mem_funct3), .mem_alu_out(mem_alu_out),
        .mem_rdata(mem_rdata), .mem_pc(mem_pc), .mem_u_imm(mem_u_imm),
        .wb_valid(wb_valid), .rf_load(rf_load), .rf_dest(rf_dest), .rf_in(rf_in),
        .instret(instret)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic step(input logic st, input logic fl, input logic v, input logic rw,
                        input logic [4:0] rd, input logic [1:0] ws, input logic [2:0] f3,
                        input logic [31:0] alu, input logic [31:0] rdata,
                        input logic [31:0] pc, input logic [31:0] uimm,
                        input logic ev, input logic el, input logic [4:0] ed,
                        input logic [31:0] ein, input logic [63:0] ecnt, input string name);
        exp_t e;
        @(negedge clk);
        stall = st; flush = fl; mem_valid = v; mem_regwrite = rw; mem_rd = rd;
        mem_wbsel = ws; mem_funct3 = f3; mem_alu_out = alu; mem_rdata = rdata;
        mem_pc = pc; mem_u_imm = uimm;
        e.v = ev; e.l = el; e.d = ed; e.din = ein;
        e.cnt = PERF ? ecnt : 64'd0;
        e.name = name;
        exp_q.push_back(e);
    endtask

    // Monitor: each queued entry describes the stage output after the next rising edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({e.name, ".wb_valid"}, {63'd0, wb_valid}, {63'd0, e.v});
            chk({e.name, ".rf_load"},  {63'd0, rf_load},  {63'd0, e.l});
            chk({e.name, ".rf_dest"},  {59'd0, rf_dest},  {59'd0, e.d});
            chk({e.name, ".rf_in"},    {32'd0, rf_in},    {32'd0, e.din});
            chk({e.name, ".instret"},  instret,           e.cnt);
            $display("txn %s: valid=%0d load=%0d dest=%0d in=%h instret=%0d",
                     e.name, wb_valid, rf_load, rf_dest, rf_in, instret);
        end
    end

    task automatic drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 20) begin
            @(posedge clk);
            #2;
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
    endtask

    initial begin
        rst = 1'b0;
        stall = 0; flush = 0; mem_valid = 0; mem_regwrite = 0; mem_rd = 0;
        mem_wbsel = 0; mem_funct3 = 0; mem_alu_out = 0; mem_rdata = 0; mem_pc = 0; mem_u_imm = 0;
        #2;
        chk("reset0.wb_valid", {63'd0, wb_valid}, 64'd0);
        chk("reset0.rf_load",  {63'd0, rf_load},  64'd0);
        chk("reset0.rf_in",    {32'd0, rf_in},    64'd0);
        chk("reset0.instret",  instret,           64'd0);
        @(negedge clk);
        rst = 1'b1;

        //   st fl v rw rd    ws     f3      alu            rdata          pc             uimm           ev el ed     ein            cnt
        step(0, 0, 1, 1, 5'd5, 2'b01, 3'b000, 32'h0000_1003, 32'h80FF_7F01, 32'h0,         32'h0,         1, 1, 5'd5,  32'hFFFF_FF80, 0,  "lb_off3");
        step(0, 0, 1, 1, 5'd5, 2'b01, 3'b100, 32'h0000_1003, 32'h80FF_7F01, 32'h0,         32'h0,         1, 1, 5'd5,  32'h0000_0080, 1,  "lbu_off3");
        step(0, 0, 1, 1, 5'd6, 2'b01, 3'b101, 32'h0000_2002, 32'hBEEF_1234, 32'h0,         32'h0,         1, 1, 5'd6,  32'h0000_BEEF, 2,  "lhu_off2");
        step(0, 0, 1, 1, 5'd6, 2'b01, 3'b001, 32'h0000_2002, 32'hBEEF_1234, 32'h0,         32'h0,         1, 1, 5'd6,  32'hFFFF_BEEF, 3,  "lh_off2");
        step(0, 0, 1, 1, 5'd6, 2'b01, 3'b101, 32'h0000_2003, 32'hBEEF_1234, 32'h0,         32'h0,         1, 1, 5'd6,  32'h0000_BEEF, 4,  "lhu_off3");
        step(0, 0, 1, 1, 5'd6, 2'b01, 3'b001, 32'h0000_2003, 32'hBEEF_1234, 32'h0,         32'h0,         1, 1, 5'd6,  32'hFFFF_BEEF, 5,  "lh_off3");
        step(0, 0, 1, 1, 5'd6, 2'b01, 3'b001, 32'h0000_2000, 32'hBEEF_8234, 32'h0,         32'h0,         1, 1, 5'd6,  32'hFFFF_8234, 6,  "lh_off0");
        step(0, 0, 1, 1, 5'd5, 2'b01, 3'b000, 32'h0000_1001, 32'h80FF_7F01, 32'h0,         32'h0,         1, 1, 5'd5,  32'h0000_007F, 7,  "lb_off1");
        step(0, 0, 1, 1, 5'd5, 2'b01, 3'b010, 32'h0000_1003, 32'h80FF_7F01, 32'h0,         32'h0,         1, 1, 5'd5,  32'h80FF_7F01, 8,  "lw_off3");
        step(0, 0, 1, 1, 5'd5, 2'b01, 3'b011, 32'h0000_1002, 32'h80FF_7F01, 32'h0,         32'h0,         1, 1, 5'd5,  32'h80FF_7F01, 9,  "f3_011_word");
        step(0, 0, 1, 1, 5'd0, 2'b00, 3'b000, 32'h1234_5678, 32'h0,         32'h0,         32'h0,         1, 0, 5'd0,  32'h1234_5678, 10, "x0_suppress");
        step(0, 0, 1, 1, 5'd7, 2'b10, 3'b000, 32'h0,         32'h0,         32'hFFFF_FFFC, 32'h0,         1, 1, 5'd7,  32'h0000_0000, 11, "pc4_wrap");
        step(0, 0, 1, 1, 5'd7, 2'b10, 3'b000, 32'h0,         32'h0,         32'h0000_0100, 32'h0,         1, 1, 5'd7,  32'h0000_0104, 12, "pc4");
        step(0, 0, 1, 1, 5'd8, 2'b11, 3'b000, 32'h0,         32'h0,         32'h0,         32'hABCD_E000, 1, 1, 5'd8,  32'hABCD_E000, 13, "lui");
        step(0, 0, 1, 0, 5'd9, 2'b00, 3'b000, 32'h0000_0055, 32'h0,         32'h0,         32'h0,         1, 0, 5'd9,  32'h0000_0055, 14, "no_regwrite");
        step(0, 0, 0, 1, 5'd10,2'b00, 3'b000, 32'h0000_0066, 32'h0,         32'h0,         32'h0,         0, 0, 5'd10, 32'h0000_0000, 15, "invalid");
        step(0, 0, 1, 1, 5'd3, 2'b00, 3'b000, 32'h0000_0007, 32'h0,         32'h0,         32'h0,         1, 1, 5'd3,  32'h0000_0007, 15, "add_rd3");
        step(1, 0, 1, 1, 5'd12,2'b00, 3'b000, 32'h0000_0099, 32'h0,         32'h0,         32'h0,         1, 1, 5'd3,  32'h0000_0007, 15, "stall1");
        step(1, 0, 1, 1, 5'd12,2'b00, 3'b000, 32'h0000_0099, 32'h0,         32'h0,         32'h0,         1, 1, 5'd3,  32'h0000_0007, 15, "stall2");
        step(1, 0, 1, 1, 5'd12,2'b01, 3'b000, 32'h0000_0098, 32'hFFFF_FFFF, 32'h0,         32'h0,         1, 1, 5'd3,  32'h0000_0007, 15, "stall3");
        step(0, 0, 1, 1, 5'd4, 2'b00, 3'b000, 32'h0000_0011, 32'h0,         32'h0,         32'h0,         1, 1, 5'd4,  32'h0000_0011, 16, "release");
        step(1, 1, 1, 1, 5'd12,2'b00, 3'b000, 32'h0000_0099, 32'h0,         32'h0,         32'h0,         0, 0, 5'd0,  32'h0000_0000, 16, "stall_flush");
        step(0, 1, 1, 1, 5'd12,2'b00, 3'b000, 32'h0000_0099, 32'h0,         32'h0,         32'h0,         0, 0, 5'd0,  32'h0000_0000, 16, "flush");
        step(0, 0, 1, 1, 5'd13,2'b00, 3'b000, 32'h0000_CAFE, 32'h0,         32'h0,         32'h0,         1, 1, 5'd13, 32'h0000_CAFE, 16, "add_rd13");
        step(1, 0, 1, 1, 5'd14,2'b00, 3'b000, 32'h0000_BEEF, 32'h0,         32'h0,         32'h0,         1, 1, 5'd13, 32'h0000_CAFE, 16, "stall_pre_rst");
        drain();

        // Pulse reset mid-cycle while stalled with nonzero inputs; outputs clear without a clock edge.
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("rst_mid.wb_valid", {63'd0, wb_valid}, 64'd0);
        chk("rst_mid.rf_load",  {63'd0, rf_load},  64'd0);
        chk("rst_mid.rf_dest",  {59'd0, rf_dest},  64'd0);
        chk("rst_mid.rf_in",    {32'd0, rf_in},    64'd0);
        chk("rst_mid.instret",  instret,           64'd0);
        @(negedge clk);
        stall = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_held.wb_valid", {63'd0, wb_valid}, 64'd0);
        @(negedge clk);
        rst = 1'b1;

        step(0, 0, 1, 1, 5'd14,2'b00, 3'b000, 32'h0000_1234, 32'h0,         32'h0,         32'h0,         1, 1, 5'd14, 32'h0000_1234, 0,  "after_rst");
        step(0, 0, 0, 0, 5'd0, 2'b00, 3'b000, 32'h0,         32'h0,         32'h0,         32'h0,         0, 0, 5'd0,  32'h0000_0000, 1,  "idle");
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
